// File: rtl/mult_ex_ctrl_if.sv
// Handshake bundle between the EX-stage multiply controller and the 16-iteration multiplier.
// The controller uses the master modport; the multiplier (or its model) uses the slave modport.
interface mult_ex_ctrl_if #(parameter int DATA_W = 32);
  logic                  mult_in_valid;
  logic [DATA_W-1:0]     mult_mplier;
  logic [DATA_W-1:0]     mult_mcand;
  logic [2*DATA_W-1:0]   mult_product;
  logic                  mult_out_valid;

  modport master (
    output mult_in_valid, mult_mplier, mult_mcand,
    input  mult_product, mult_out_valid
  );

  modport slave (
    input  mult_in_valid, mult_mplier, mult_mcand,
    output mult_product, mult_out_valid
  );
endinterface

// File: rtl/mult_ex_ctrl.sv
// EX-stage front end for the unsigned iterative multiplier: stalls EX, sends magnitudes, sign-corrects the product.
// Optional result reuse of the last completed operation is enabled by defining MULT_REUSE_EN.
module mult_ex_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [1:0]        ex_funct,
  input  logic [DATA_W-1:0] ex_rs1,
  input  logic [DATA_W-1:0] ex_rs2,
  input  logic              ex_flush,
  output logic              ex_stall,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  mult_ex_ctrl_if.master    mult
);

  localparam logic [1:0] F_MUL    = 2'b00;
  localparam logic [1:0] F_MULH   = 2'b01;
  localparam logic [1:0] F_MULHSU = 2'b10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t                state_r, state_s;
  logic [DATA_W-1:0]     mplier_r, mcand_r;
  logic                  neg_r;
  logic [1:0]            funct_r;
  logic [2*DATA_W-1:0]   res_r;

  logic                  sa_s, sb_s, neg_s, start_s, hit_s, load_res_s;
  logic [2*DATA_W-1:0]   prod_fix_s;

  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v, input logic is_signed);
    return (is_signed && v[DATA_W-1]) ? (~v + {{(DATA_W-1){1'b0}}, 1'b1}) : v;
  endfunction

  // MUL runs as signed*signed; its low word is the same for any signedness.
  assign sa_s       = (ex_funct == F_MUL) || (ex_funct == F_MULH) || (ex_funct == F_MULHSU);
  assign sb_s       = (ex_funct == F_MUL) || (ex_funct == F_MULH);
  assign neg_s      = (sa_s & ex_rs1[DATA_W-1]) ^ (sb_s & ex_rs2[DATA_W-1]);
  assign start_s    = ex_valid && !ex_flush;
  assign load_res_s = (state_r == WAIT) && mult.mult_out_valid && !ex_flush;
  assign prod_fix_s = neg_r ? (~mult.mult_product + {{(2*DATA_W-1){1'b0}}, 1'b1}) : mult.mult_product;

`ifdef MULT_REUSE_EN
  logic [DATA_W-1:0] key_a_r, key_b_r;
  logic              key_sa_r, key_sb_r, key_vld_r;

  assign hit_s = key_vld_r && (ex_rs1 == key_a_r) && (ex_rs2 == key_b_r) &&
                 ((ex_funct == F_MUL) || ({sa_s, sb_s} == {key_sa_r, key_sb_r}));

  // Reuse key register; operands are still held by EX when the product lands, so capture them then.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_a_r   <= {DATA_W{1'b0}};
      key_b_r   <= {DATA_W{1'b0}};
      key_sa_r  <= 1'b0;
      key_sb_r  <= 1'b0;
      key_vld_r <= 1'b0;
    end else if (load_res_s) begin
      key_a_r   <= ex_rs1;
      key_b_r   <= ex_rs2;
      key_sa_r  <= sa_s;
      key_sb_r  <= sb_s;
      key_vld_r <= 1'b1;
    end
  end
`else
  assign hit_s = 1'b0;
`endif

  // State, operand and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      mplier_r <= {DATA_W{1'b0}};
      mcand_r  <= {DATA_W{1'b0}};
      neg_r    <= 1'b0;
      funct_r  <= 2'b00;
      res_r    <= {(2*DATA_W){1'b0}};
    end else begin
      state_r <= state_s;
      if ((state_r == IDLE) && start_s) begin
        mplier_r <= magnitude(ex_rs1, sa_s);
        mcand_r  <= magnitude(ex_rs2, sb_s);
        neg_r    <= neg_s;
        funct_r  <= ex_funct;
      end
      if (load_res_s) begin
        res_r <= prod_fix_s;
      end
    end
  end

  // Next-state logic; a flush that coincides with the done pulse needs no drain.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          if (hit_s) state_s = DONE;
          else       state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (ex_flush) state_s = DRAIN;
        else          state_s = WAIT;
      end
      WAIT: begin
        if (ex_flush && mult.mult_out_valid)  state_s = IDLE;
        else if (ex_flush)                    state_s = DRAIN;
        else if (mult.mult_out_valid)         state_s = DONE;
        else                                  state_s = WAIT;
      end
      DONE:    state_s = IDLE;
      DRAIN: begin
        if (mult.mult_out_valid) state_s = IDLE;
        else                     state_s = DRAIN;
      end
      default: state_s = IDLE;
    endcase
  end

  assign ex_stall = ((state_r == IDLE) && start_s) || (state_r == ISSUE) || (state_r == WAIT) ||
                    ((state_r == DRAIN) && ex_valid);
  assign res_valid = (state_r == DONE);
  assign res_data  = (state_r != DONE) ? {DATA_W{1'b0}} :
                     (funct_r == F_MUL) ? res_r[DATA_W-1:0] : res_r[2*DATA_W-1:DATA_W];

  assign mult.mult_in_valid = (state_r == ISSUE);
  assign mult.mult_mplier   = mplier_r;
  assign mult.mult_mcand    = mcand_r;

endmodule

// File: tb/tb_mult_ex_ctrl.sv
// Self-checking bench for mult_ex_ctrl: behavioural multiplier with random latency plus a
// signed-arithmetic reference; reuse expectations follow MULT_REUSE_EN.
module tb_mult_ex_ctrl;

  localparam logic [1:0] F_MUL    = 2'b00;
  localparam logic [1:0] F_MULH   = 2'b01;
  localparam logic [1:0] F_MULHSU = 2'b10;
  localparam logic [1:0] F_MULHU  = 2'b11;
`ifdef MULT_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [1:0]  ex_funct;
  logic [31:0] ex_rs1, ex_rs2;
  logic        ex_flush;
  logic        ex_stall, res_valid;
  logic [31:0] res_data;

  mult_ex_ctrl_if #(.DATA_W(32)) mif ();

  mult_ex_ctrl #(.DATA_W(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ex_valid (ex_valid),
    .ex_funct (ex_funct),
    .ex_rs1   (ex_rs1),
    .ex_rs2   (ex_rs2),
    .ex_flush (ex_flush),
    .ex_stall (ex_stall),
    .res_valid(res_valid),
    .res_data (res_data),
    .mult     (mif)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int starts   = 0;
  int overlaps = 0;

  bit          key_vld = 1'b0;
  logic [31:0] key_a, key_b;
  logic [1:0]  key_f;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // {A signed, B signed} for each operation; MUL treated as signed*signed.
  function automatic logic [1:0] sign_class(input logic [1:0] f);
    case (f)
      F_MULHU:  return 2'b00;
      F_MULHSU: return 2'b10;
      default:  return 2'b11;
    endcase
  endfunction

  function automatic logic [31:0] ref_res(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [1:0]  c;
    logic [63:0] ea, eb, p;
    c  = sign_class(f);
    ea = c[1] ? {{32{a[31]}}, a} : {32'd0, a};
    eb = c[0] ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ea * eb;
    return (f == F_MUL) ? p[31:0] : p[63:32];
  endfunction

  function automatic bit model_hit(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    return REUSE && key_vld && (a == key_a) && (b == key_b) &&
           ((f == F_MUL) || (sign_class(f) == sign_class(key_f)));
  endfunction

  // Behavioural iterative multiplier: random latency, one-cycle done pulse, cleared by reset.
  initial begin : mult_model
    int          cnt;
    bit          busy;
    logic [63:0] p;
    busy = 1'b0;
    cnt  = 0;
    p    = 64'd0;
    mif.mult_out_valid = 1'b0;
    mif.mult_product   = 64'd0;
    forever begin
      @(negedge clk);
      mif.mult_out_valid = 1'b0;
      if (!rst_n) begin
        busy = 1'b0;
      end else if (busy) begin
        if (mif.mult_in_valid) overlaps++;
        if (cnt == 0) begin
          mif.mult_product   = p;
          mif.mult_out_valid = 1'b1;
          busy = 1'b0;
        end else begin
          cnt--;
        end
      end else if (mif.mult_in_valid) begin
        p    = {32'd0, mif.mult_mplier} * {32'd0, mif.mult_mcand};
        cnt  = $urandom_range(17, 13);
        busy = 1'b1;
        starts++;
      end
    end
  end

  task automatic wait_result(input string tag, input logic [31:0] exp, input int s0,
                             input int exp_pulses, input bit chk_one_stall);
    int stalls;
    int bad;
    bit got;
    stalls = 0;
    bad    = 0;
    got    = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      #1;
      if (res_valid) begin
        got = 1'b1;
        check_eq({tag, "_data"}, res_data, exp);
        check_eq({tag, "_stall_at_res"}, ex_stall, 1'b0);
      end else begin
        if (ex_stall) stalls++;
        else          bad++;
        @(negedge clk);
      end
    end
    check_eq({tag, "_got_result"}, got, 1'b1);
    check_eq({tag, "_stall_held"}, bad, 0);
    check_eq({tag, "_pulses"}, starts - s0, exp_pulses);
    if (chk_one_stall) check_eq({tag, "_hit_stall"}, stalls, 1);
  endtask

  task automatic run_op(input string tag, input logic [1:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input bit drain);
    bit hit;
    int s0;
    hit = model_hit(f, a, b);
    @(negedge clk);
    s0       = starts;
    ex_valid = 1'b1;
    ex_flush = 1'b0;
    ex_funct = f;
    ex_rs1   = a;
    ex_rs2   = b;
    wait_result(tag, exp, s0, hit ? 0 : 1, hit && !drain);
    if (!hit) begin
      key_vld = 1'b1;
      key_a   = a;
      key_b   = b;
      key_f   = f;
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    ex_valid = 1'b0;
    ex_flush = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_stall"},   ex_stall, 1'b0);
    check_eq({tag, "_rvalid"},  res_valid, 1'b0);
    check_eq({tag, "_rdata"},   res_data, 32'd0);
    check_eq({tag, "_invalid"}, mif.mult_in_valid, 1'b0);
    check_eq({tag, "_mplier"},  mif.mult_mplier, 32'd0);
    check_eq({tag, "_mcand"},   mif.mult_mcand, 32'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(5, 0))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin : main
    int          s0;
    logic [1:0]  rf;
    logic [31:0] ra, rb;
    rst_n    = 1'b0;
    ex_valid = 1'b0;
    ex_flush = 1'b0;
    ex_funct = 2'b00;
    ex_rs1   = 32'd0;
    ex_rs2   = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_op("t1_mulhu", F_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    run_op("t2_mul", F_MUL, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 1'b0);
    check_eq("t2_mplier", mif.mult_mplier, 32'd3);
    check_eq("t2_mcand", mif.mult_mcand, 32'd7);
    run_op("t2_mulh", F_MULH, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 1'b0);
    run_op("t3_mulh", F_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
    run_op("t3_mulhsu", F_MULHSU, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, 1'b0);

    // Flush while the multiplier is running, then a new op held through the drain.
    idle_cycle();
    s0 = starts;
    @(negedge clk);
    ex_valid = 1'b1;
    ex_funct = F_MULHU;
    ex_rs1   = 32'h1234_5678;
    ex_rs2   = 32'h9ABC_DEF0;
    for (int c = 0; c < 10 && starts == s0; c++) @(negedge clk);
    check_eq("t4_issued", starts - s0, 1);
    repeat (2) @(negedge clk);
    ex_flush = 1'b1;
    #1;
    check_eq("t4_wait_stall", ex_stall, 1'b1);
    @(negedge clk);
    ex_flush = 1'b0;
    ex_valid = 1'b0;
    #1;
    check_eq("t4_drain_stall", ex_stall, 1'b0);
    check_eq("t4_drain_rvalid", res_valid, 1'b0);
    run_op("t4_after", F_MUL, 32'd5, 32'd6, 32'd30, 1'b1);

    // Flush in ISSUE: the start pulse still goes out.
    idle_cycle();
    @(negedge clk);
    ex_valid = 1'b1;
    ex_funct = F_MULH;
    ex_rs1   = 32'h0BAD_F00D;
    ex_rs2   = 32'hF00D_0BAD;
    @(negedge clk);
    ex_flush = 1'b1;
    #1;
    check_eq("t4i_pulse", mif.mult_in_valid, 1'b1);
    @(negedge clk);
    ex_flush = 1'b0;
    ex_valid = 1'b0;
    #1;
    check_eq("t4i_drain_stall", ex_stall, 1'b0);
    check_eq("t4i_drain_rvalid", res_valid, 1'b0);
    run_op("t4i_after", F_MULHSU, 32'hFFFF_FFFF, 32'd9, 32'hFFFF_FFFF, 1'b1);

    // Reset in the middle of a multiply.
    idle_cycle();
    s0 = starts;
    @(negedge clk);
    ex_valid = 1'b1;
    ex_funct = F_MULHU;
    ex_rs1   = 32'hDEAD_BEEF;
    ex_rs2   = 32'h0000_1001;
    for (int c = 0; c < 10 && starts == s0; c++) @(negedge clk);
    check_eq("t5_issued", starts - s0, 1);
    repeat (5) @(negedge clk);
    rst_n    = 1'b0;
    ex_valid = 1'b0;
    @(negedge clk);
    #1;
    check_all_zero("t5_reset");
    @(negedge clk);
    rst_n   = 1'b1;
    key_vld = 1'b0;
    run_op("t5_mul", F_MUL, 32'd2, 32'd3, 32'd6, 1'b0);

    // Reuse sequence; key cleared by reset first.
    idle_cycle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n   = 1'b1;
    key_vld = 1'b0;
    run_op("t6_mulh", F_MULH, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 1'b0);
    run_op("t6_mul", F_MUL, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 1'b0);
    run_op("t6_mulhu", F_MULHU, 32'hFFFF_FFFD, 32'd7, 32'd6, 1'b0);

    ra = 32'd0;
    rb = 32'd0;
    for (int i = 0; i < 24; i++) begin
      rf = 2'($urandom_range(3, 0));
      if (i == 0 || $urandom_range(2, 0) != 0) begin
        ra = pick_operand();
        rb = pick_operand();
      end
      run_op("rand", rf, ra, rb, ref_res(rf, ra, rb), 1'b0);
    end

    idle_cycle();
    repeat (25) @(negedge clk);
    check_eq("no_overlap", overlaps, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
